// File: rtl/tl_scratch_arbiter_pkg.sv
// Shared defaults, datapath widths and state encoding for the scratch-memory / adder arbiter.
package tl_scratch_arbiter_pkg;

  localparam int unsigned ARB_NREQ_DEF    = 4;
  localparam int unsigned ARB_TIMEOUT_DEF = 4096;

  localparam int unsigned ADD_W  = 16;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN  = 2'd1,
    ARB_GAP  = 2'd2
  } arb_state_e;

  // Index width that stays at least one bit wide.
  function automatic int unsigned idx_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tl_scratch_arbiter_rr_priority_pick.sv
// Combinational round-robin pick: first requester at or after the pointer, wrapping modulo NREQ.
module rr_priority_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDXW = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDXW-1:0] i_rr_ptr,
  output logic            o_valid,
  output logic [IDXW-1:0] o_idx
);

  int w_dist;
  int w_best;

  // Pick the requester with the smallest circular distance from the pointer.
  always_comb begin
    o_valid = |i_req;
    o_idx   = '0;
    w_best  = int'(NREQ);
    w_dist  = 0;
    for (int j = 0; j < int'(NREQ); j++) begin
      w_dist = j - int'(i_rr_ptr);
      if (w_dist < 0) begin
        w_dist = w_dist + int'(NREQ);
      end
      if (i_req[j] && (w_dist < w_best)) begin
        w_best = w_dist;
        o_idx  = IDXW'(j);
      end
    end
  end

endmodule

// File: rtl/tl_scratch_arbiter.sv
// Round-robin owner of the scratch-memory ports and the shared adder; a grant lasts a whole
// requester operation and is followed by one dead cycle before the next arbitration.
module tl_scratch_arbiter
  import tl_scratch_arbiter_pkg::*;
#(
  parameter int unsigned NREQ    = ARB_NREQ_DEF,
  parameter int unsigned TIMEOUT = ARB_TIMEOUT_DEF
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          done_in,
  input  logic [ADD_W*NREQ-1:0]    add_a_in,
  input  logic [ADD_W*NREQ-1:0]    add_b_in,
  input  logic [ADDR_W*NREQ-1:0]   waddr_in,
  input  logic [DATA_W*NREQ-1:0]   wdata_in,
  input  logic [NREQ-1:0]          we_in,
  input  logic [ADDR_W*NREQ-1:0]   raddr_in,
  output logic [NREQ-1:0]          gnt,
  output logic                     busy,
  output logic                     err_timeout,
  output logic [ADD_W-1:0]         add_a_out,
  output logic [ADD_W-1:0]         add_b_out,
  output logic [ADDR_W-1:0]        mem_waddr,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_raddr
);

  localparam int unsigned     IDXW       = idx_w(NREQ);
  localparam int unsigned     WDW        = $clog2(TIMEOUT);
  localparam logic [WDW-1:0]  WDOG_LAST  = WDW'(TIMEOUT - 1);
  localparam logic [IDXW-1:0] OWNER_LAST = IDXW'(NREQ - 1);

  arb_state_e      r_state, w_state_nxt;
  logic [NREQ-1:0] r_gnt, w_gnt_nxt;
  logic [IDXW-1:0] r_owner, w_owner_nxt;
  logic [IDXW-1:0] r_rr_ptr, w_rr_ptr_nxt;
  logic [WDW-1:0]  r_wdog, w_wdog_nxt;
  logic            r_err, w_err_nxt;

  logic            w_pick_valid;
  logic [IDXW-1:0] w_pick_idx;
  logic            w_own_req;
  logic            w_own_done;
  logic            w_timeout;
  logic            w_release;

  rr_priority_pick #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_pick (
    .i_req    (req),
    .i_rr_ptr (r_rr_ptr),
    .o_valid  (w_pick_valid),
    .o_idx    (w_pick_idx)
  );

  // Owner select: control bits always follow the owner, datapath only while it owns.
  always_comb begin
    w_own_req  = 1'b0;
    w_own_done = 1'b0;
    add_a_out  = '0;
    add_b_out  = '0;
    mem_waddr  = '0;
    mem_wdata  = '0;
    mem_we     = 1'b0;
    mem_raddr  = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (r_owner == IDXW'(i)) begin
        w_own_req  = req[i];
        w_own_done = done_in[i];
        if (r_state == ARB_OWN) begin
          add_a_out = add_a_in[ADD_W*i +: ADD_W];
          add_b_out = add_b_in[ADD_W*i +: ADD_W];
          mem_waddr = waddr_in[ADDR_W*i +: ADDR_W];
          mem_wdata = wdata_in[DATA_W*i +: DATA_W];
          mem_we    = we_in[i];
          mem_raddr = raddr_in[ADDR_W*i +: ADDR_W];
        end
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_gnt_nxt    = r_gnt;
    w_owner_nxt  = r_owner;
    w_rr_ptr_nxt = r_rr_ptr;
    w_wdog_nxt   = r_wdog;
    w_err_nxt    = r_err;
    w_timeout    = (r_wdog == WDOG_LAST);
    w_release    = w_own_done || !w_own_req || w_timeout;
    case (r_state)
      ARB_IDLE: begin
        if (w_pick_valid) begin
          w_gnt_nxt   = NREQ'(1) << w_pick_idx;
          w_owner_nxt = w_pick_idx;
          w_wdog_nxt  = '0;
          w_state_nxt = ARB_OWN;
        end
      end
      ARB_OWN: begin
        if (w_release) begin
          w_gnt_nxt    = '0;
          w_rr_ptr_nxt = (r_owner == OWNER_LAST) ? '0 : r_owner + IDXW'(1);
          w_state_nxt  = ARB_GAP;
          // Only a watchdog release that the requester did not ask for is an error.
          if (w_timeout && w_own_req && !w_own_done) begin
            w_err_nxt = 1'b1;
          end
        end else begin
          w_wdog_nxt = r_wdog + WDW'(1);
        end
      end
      ARB_GAP: begin
        w_state_nxt = ARB_IDLE;
      end
      default: begin
        w_state_nxt = ARB_IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= ARB_IDLE;
      r_gnt    <= '0;
      r_owner  <= '0;
      r_rr_ptr <= '0;
      r_wdog   <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_gnt    <= w_gnt_nxt;
      r_owner  <= w_owner_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
      r_wdog   <= w_wdog_nxt;
      r_err    <= w_err_nxt;
    end
  end

  assign gnt         = r_gnt;
  assign busy        = (r_state == ARB_OWN);
  assign err_timeout = r_err;

endmodule

// File: tb/tb_tl_scratch_arbiter.sv
// Self-checking bench for tl_scratch_arbiter: directed scenarios plus randomized traffic
// checked against a cycle-level ownership model.
module tb_tl_scratch_arbiter;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 16;

  logic                 clock;
  logic                 reset;
  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      done_in;
  logic [16*NREQ-1:0]   add_a_in;
  logic [16*NREQ-1:0]   add_b_in;
  logic [12*NREQ-1:0]   waddr_in;
  logic [32*NREQ-1:0]   wdata_in;
  logic [NREQ-1:0]      we_in;
  logic [12*NREQ-1:0]   raddr_in;
  logic [NREQ-1:0]      gnt;
  logic                 busy;
  logic                 err_timeout;
  logic [15:0]          add_a_out;
  logic [15:0]          add_b_out;
  logic [11:0]          mem_waddr;
  logic [31:0]          mem_wdata;
  logic                 mem_we;
  logic [11:0]          mem_raddr;

  tl_scratch_arbiter #(
    .NREQ    (NREQ),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .done_in     (done_in),
    .add_a_in    (add_a_in),
    .add_b_in    (add_b_in),
    .waddr_in    (waddr_in),
    .wdata_in    (wdata_in),
    .we_in       (we_in),
    .raddr_in    (raddr_in),
    .gnt         (gnt),
    .busy        (busy),
    .err_timeout (err_timeout),
    .add_a_out   (add_a_out),
    .add_b_out   (add_b_out),
    .mem_waddr   (mem_waddr),
    .mem_wdata   (mem_wdata),
    .mem_we      (mem_we),
    .mem_raddr   (mem_raddr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: who owns, how long, dead cycles left, next priority, sticky error.
  int m_owner;
  int m_held;
  int m_gap;
  int m_ptr;
  bit m_err;

  logic [15:0] e_a, e_b;
  logic [11:0] e_waddr, e_raddr;
  logic [31:0] e_wdata;
  logic        e_we;

  task automatic model_reset();
    m_owner = -1;
    m_held  = 0;
    m_gap   = 0;
    m_ptr   = 0;
    m_err   = 1'b0;
  endtask

  task automatic model_step();
    bit own_done, own_req;
    int j;
    if (m_owner >= 0) begin
      own_done = ((done_in >> m_owner) & 4'b0001) != 0;
      own_req  = ((req >> m_owner) & 4'b0001) != 0;
      m_held++;
      if (own_done || !own_req || m_held == TIMEOUT) begin
        if (!own_done && own_req) m_err = 1'b1;
        m_ptr   = (m_owner + 1) % NREQ;
        m_owner = -1;
        m_gap   = 1;
      end
    end else if (m_gap > 0) begin
      m_gap = 0;
    end else if (req != 0) begin
      for (int k = 0; k < NREQ; k++) begin
        j = (m_ptr + k) % NREQ;
        if (((req >> j) & 4'b0001) != 0) begin
          m_owner = j;
          m_held  = 0;
          break;
        end
      end
    end
  endtask

  function automatic logic [NREQ-1:0] m_gnt();
    return (m_owner >= 0) ? NREQ'(1 << m_owner) : '0;
  endfunction

  task automatic model_dp();
    if (m_owner >= 0) begin
      e_a     = 16'(add_a_in >> (16 * m_owner));
      e_b     = 16'(add_b_in >> (16 * m_owner));
      e_waddr = 12'(waddr_in >> (12 * m_owner));
      e_wdata = 32'(wdata_in >> (32 * m_owner));
      e_we    = 1'((we_in >> m_owner) & 4'b0001);
      e_raddr = 12'(raddr_in >> (12 * m_owner));
    end else begin
      e_a = '0; e_b = '0; e_waddr = '0; e_wdata = '0; e_we = 1'b0; e_raddr = '0;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    if (reset) model_reset();
    else model_step();
    #1;
  endtask

  task automatic rand_data();
    for (int i = 0; i < NREQ; i++) begin
      add_a_in[16*i +: 16] = 16'($urandom);
      add_b_in[16*i +: 16] = 16'($urandom);
      waddr_in[12*i +: 12] = 12'($urandom);
      wdata_in[32*i +: 32] = $urandom;
      raddr_in[12*i +: 12] = 12'($urandom);
    end
    we_in = 4'($urandom);
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    req     = '0;
    done_in = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rand_data();
    req = 4'hF;
    done_in = '0;
    tick();
    tick();
    n_checks++;
    if (gnt !== 4'b0000) begin
      n_errors++; $display("FAIL reset_gnt: got %b exp 0000", gnt);
    end
    n_checks++;
    if (busy !== 1'b0 || err_timeout !== 1'b0) begin
      n_errors++; $display("FAIL reset_flags: got busy=%b err=%b exp 0 0", busy, err_timeout);
    end
    reset = 1'b0;
    req = '0;
    rand_data();
    we_in = 4'hF;
    #1;
    n_checks++;
    if (add_a_out !== 16'h0 || mem_we !== 1'b0 || mem_raddr !== 12'h0 || mem_wdata !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_dp: got a=%h we=%b raddr=%h wdata=%h exp all 0",
               add_a_out, mem_we, mem_raddr, mem_wdata);
    end
  endtask

  task automatic test_single_grant();
    do_reset();
    rand_data();
    req = 4'b0100;
    tick();
    n_checks++;
    if (gnt !== 4'b0100 || busy !== 1'b1) begin
      n_errors++; $display("FAIL single_gnt: got %b busy=%b exp 0100 busy=1", gnt, busy);
    end
    for (int k = 0; k < 3; k++) begin
      rand_data();
      #1;
      model_dp();
      n_checks++;
      if (mem_raddr !== raddr_in[24 +: 12] || add_a_out !== e_a || mem_wdata !== e_wdata) begin
        n_errors++;
        $display("FAIL single_dp: got raddr=%h a=%h wdata=%h exp raddr=%h a=%h wdata=%h",
                 mem_raddr, add_a_out, mem_wdata, raddr_in[24 +: 12], e_a, e_wdata);
      end
      tick();
    end
    done_in = 4'b0100;
    tick();
    done_in = '0;
    req = '0;
    n_checks++;
    if (gnt !== 4'b0000) begin
      n_errors++; $display("FAIL single_release: got %b exp 0000", gnt);
    end
  endtask

  task automatic test_two_req();
    logic [NREQ-1:0] seen [3];
    do_reset();
    req = 4'b1010;
    tick();
    n_checks++;
    if (gnt !== 4'b0010) begin
      n_errors++; $display("FAIL two_first: got %b exp 0010", gnt);
    end
    tick();
    done_in = 4'b0010;
    tick();
    done_in = '0;
    req = 4'b1000;
    seen[0] = gnt;
    tick();
    seen[1] = gnt;
    tick();
    seen[2] = gnt;
    n_checks++;
    if (seen[0] !== 4'b0000 || seen[1] !== 4'b0000 || seen[2] !== 4'b1000) begin
      n_errors++;
      $display("FAIL two_gap: got %b,%b,%b exp 0000,0000,1000", seen[0], seen[1], seen[2]);
    end
    done_in = 4'b1000;
    tick();
    done_in = '0;
    req = '0;
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] prev, exp_g;
    bit found;
    do_reset();
    req  = 4'hF;
    prev = '0;
    for (int g = 0; g < 5; g++) begin
      found = 1'b0;
      for (int k = 0; k < 8; k++) begin
        if (gnt != 0) begin
          found = 1'b1;
          break;
        end
        tick();
      end
      exp_g = NREQ'(1 << (g % NREQ));
      n_checks++;
      if (!found || gnt !== exp_g || gnt === prev) begin
        n_errors++;
        $display("FAIL rr_order%0d: got %b (prev %b) exp %b", g, gnt, prev, exp_g);
      end
      prev = gnt;
      for (int k = 0; k < 4; k++) tick();
      n_checks++;
      if (gnt !== prev) begin
        n_errors++; $display("FAIL rr_hold%0d: got %b exp %b", g, gnt, prev);
      end
      done_in = gnt;
      tick();
      done_in = '0;
    end
    req = '0;
    tick();
    tick();
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    req = 4'b0001;
    tick();
    n = 1;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (gnt == 0) break;
      n++;
    end
    req = '0;
    n_checks++;
    if (n !== TIMEOUT) begin
      n_errors++; $display("FAIL timeout_len: got %0d own cycles exp %0d", n, TIMEOUT);
    end
    n_checks++;
    if (err_timeout !== 1'b1) begin
      n_errors++; $display("FAIL timeout_err: got %b exp 1", err_timeout);
    end
    for (int k = 0; k < 5; k++) tick();
    n_checks++;
    if (err_timeout !== 1'b1) begin
      n_errors++; $display("FAIL timeout_sticky: got %b exp 1", err_timeout);
    end
    do_reset();
    n_checks++;
    if (err_timeout !== 1'b0) begin
      n_errors++; $display("FAIL timeout_clear: got %b exp 0", err_timeout);
    end
  endtask

  task automatic test_reset_mid_own();
    do_reset();
    req = 4'b0010;
    tick();
    done_in = 4'b0010;
    tick();
    done_in = '0;
    req = '0;
    tick();
    tick();
    req = 4'b0100;
    tick();
    we_in = 4'b0100;
    #1;
    n_checks++;
    if (gnt !== 4'b0100 || mem_we !== 1'b1) begin
      n_errors++; $display("FAIL rst_own_setup: got gnt=%b we=%b exp 0100 1", gnt, mem_we);
    end
    reset = 1'b1;
    tick();
    n_checks++;
    if (gnt !== 4'b0000 || mem_we !== 1'b0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_own_drop: got gnt=%b we=%b busy=%b exp 0000 0 0", gnt, mem_we, busy);
    end
    reset = 1'b0;
    req = 4'hF;
    tick();
    n_checks++;
    if (gnt !== 4'b0001) begin
      n_errors++; $display("FAIL rst_own_ptr: got %b exp 0001", gnt);
    end
    done_in = 4'b0001;
    req = '0;
    tick();
    done_in = '0;
  endtask

  task automatic test_foreign_done();
    do_reset();
    req = 4'b0010;
    tick();
    for (int k = 0; k < 6; k++) begin
      rand_data();
      we_in = 4'b1000;
      done_in = 4'b1000;
      #1;
      n_checks++;
      if (mem_we !== 1'b0 || mem_waddr !== waddr_in[12 +: 12]) begin
        n_errors++;
        $display("FAIL foreign_we: got we=%b waddr=%h exp 0 %h", mem_we, mem_waddr, waddr_in[12 +: 12]);
      end
      tick();
      n_checks++;
      if (gnt !== 4'b0010) begin
        n_errors++; $display("FAIL foreign_done: got %b exp 0010", gnt);
      end
    end
    done_in = 4'b0010;
    tick();
    done_in = '0;
    req = '0;
  endtask

  task automatic test_random();
    int own_cnt [NREQ];
    int dur [NREQ];
    bit just_done [NREQ];
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      own_cnt[i] = 0; dur[i] = 1; just_done[i] = 1'b0;
    end
    for (int c = 0; c < 3000; c++) begin
      rand_data();
      done_in = '0;
      for (int i = 0; i < NREQ; i++) begin
        if (m_owner == i) begin
          own_cnt[i]++;
          // Durations never land on the watchdog cycle itself.
          if (own_cnt[i] == 1) begin
            dur[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 24))
                                                 : int'($urandom_range(1, 10));
          end
          if (own_cnt[i] == dur[i]) begin
            done_in[i] = 1'b1;
            just_done[i] = 1'b1;
          end else if ($urandom_range(0, 59) == 0) begin
            req[i] = 1'b0;
          end
        end else begin
          own_cnt[i] = 0;
          if (just_done[i]) begin
            req[i] = 1'($urandom_range(0, 1));
            just_done[i] = 1'b0;
          end else if (!req[i] && $urandom_range(0, 3) == 0) begin
            req[i] = 1'b1;
          end
          if ($urandom_range(0, 7) == 0) done_in[i] = 1'b1;
        end
      end
      reset = ($urandom_range(0, 599) == 0);
      #1;
      model_dp();
      n_checks++;
      if (add_a_out !== e_a || add_b_out !== e_b || mem_waddr !== e_waddr ||
          mem_wdata !== e_wdata || mem_we !== e_we || mem_raddr !== e_raddr) begin
        n_errors++;
        $display("FAIL rand_dp@%0d: got %h %h %h %h %b %h exp %h %h %h %h %b %h", c,
                 add_a_out, add_b_out, mem_waddr, mem_wdata, mem_we, mem_raddr,
                 e_a, e_b, e_waddr, e_wdata, e_we, e_raddr);
      end
      tick();
      reset = 1'b0;
      n_checks++;
      if (gnt !== m_gnt() || busy !== (m_owner >= 0) || err_timeout !== m_err) begin
        n_errors++;
        $display("FAIL rand_ctl@%0d: got gnt=%b busy=%b err=%b exp gnt=%b busy=%b err=%b", c,
                 gnt, busy, err_timeout, m_gnt(), (m_owner >= 0), m_err);
      end
    end
    req = '0;
    done_in = '0;
  endtask

  initial begin
    reset = 1'b1;
    req = '0;
    done_in = '0;
    add_a_in = '0; add_b_in = '0; waddr_in = '0; wdata_in = '0; we_in = '0; raddr_in = '0;
    model_reset();
    test_reset();
    test_single_grant();
    test_two_req();
    test_round_robin();
    test_timeout();
    test_reset_mid_own();
    test_foreign_done();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL sim_timeout: got no completion exp finish before 2000000");
    $fatal(1, "simulation time limit");
  end

endmodule
